id_regfile_mp: RTL and testbench

//  Parametrised multi-port integer register file with write-through bypass and per-register busy scoreboard.

---
 rtl/id_regfile_mp.sv | 104 ++++++++++
 tb/tb_id_regfile_mp.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_regfile_mp.sv
// rtl/id_regfile_mp.sv - multi-port integer register file with write-through bypass and busy scoreboard
module id_regfile_mp #(
    parameter int XLEN = 64,
    parameter int NREG = 32,
    parameter int NR   = 2,
    parameter int NW   = 2,
    localparam int IW  = $clog2(NREG)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NR-1:0]        rd_en_i,
    input  logic [NR*IW-1:0]     rd_idx_i,
    output logic [NR*XLEN-1:0]   rd_data_o,
    output logic [NR-1:0]        rd_busy_o,
    input  logic [NW-1:0]        wr_en_i,
    input  logic [NW*IW-1:0]     wr_idx_i,
    input  logic [NW*XLEN-1:0]   wr_data_i,
    input  logic [NW-1:0]        wr_clr_i,
    input  logic                 iss_en_i,
    input  logic [IW-1:0]        iss_idx_i,
    output logic [NREG-1:0]      busy_o,
    output logic [IW:0]          busy_cnt_o
);

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_next;
    logic [IW:0]     cnt_next;

    // Later ports overwrite earlier ones through NBA ordering, giving the higher port priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                regs[r] <= '0;
            end
        end else begin
            for (int p = 0; p < NW; p++) begin
                if (wr_en_i[p] && wr_idx_i[p*IW +: IW] != '0) begin
                    regs[wr_idx_i[p*IW +: IW]] <= wr_data_i[p*XLEN +: XLEN];
                end
            end
        end
    end

    // Clears applied first so that an issue to the same register wins.
    always_comb begin
        busy_next = busy_q;
        for (int p = 0; p < NW; p++) begin
            if (wr_en_i[p] && wr_clr_i[p]) begin
                busy_next[wr_idx_i[p*IW +: IW]] = 1'b0;
            end
        end
        if (iss_en_i) begin
            busy_next[iss_idx_i] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_comb begin
        cnt_next = '0;
        for (int r = 0; r < NREG; r++) begin
            cnt_next = cnt_next + (IW+1)'(busy_next[r]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q     <= '0;
            busy_cnt_o <= '0;
        end else begin
            busy_q     <= busy_next;
            busy_cnt_o <= cnt_next;
        end
    end

    assign busy_o = busy_q;

    // Bypassed writeback data is valid, so a clearing write in the same cycle hides the busy bit.
    always_comb begin
        rd_data_o = '0;
        rd_busy_o = '0;
        for (int p = 0; p < NR; p++) begin
            logic [IW-1:0]   ridx;
            logic [XLEN-1:0] rdata;
            logic            hit_clr;
            ridx    = rd_idx_i[p*IW +: IW];
            rdata   = regs[ridx];
            hit_clr = 1'b0;
            for (int w = 0; w < NW; w++) begin
                if (wr_en_i[w] && wr_idx_i[w*IW +: IW] == ridx) begin
                    rdata = wr_data_i[w*XLEN +: XLEN];
                    if (wr_clr_i[w]) begin
                        hit_clr = 1'b1;
                    end
                end
            end
            if (rd_en_i[p] && ridx != '0) begin
                rd_data_o[p*XLEN +: XLEN] = rdata;
                rd_busy_o[p]              = busy_q[ridx] & ~hit_clr;
            end
        end
    end

endmodule

// File: tb/tb_id_regfile_mp.sv
// tb/tb_id_regfile_mp.sv - self-checking bench for id_regfile_mp
module tb_id_regfile_mp;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   rd_en;
    logic [9:0]   rd_idx;
    logic [127:0] rd_data;
    logic [1:0]   rd_busy;
    logic [1:0]   wr_en;
    logic [9:0]   wr_idx;
    logic [127:0] wr_data;
    logic [1:0]   wr_clr;
    logic         iss_en;
    logic [4:0]   iss_idx;
    logic [31:0]  busy;
    logic [5:0]   busy_cnt;

    int n_cmp = 0;
    int n_err = 0;

    id_regfile_mp #(.XLEN(64), .NREG(32), .NR(2), .NW(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .rd_en_i    (rd_en),
        .rd_idx_i   (rd_idx),
        .rd_data_o  (rd_data),
        .rd_busy_o  (rd_busy),
        .wr_en_i    (wr_en),
        .wr_idx_i   (wr_idx),
        .wr_data_i  (wr_data),
        .wr_clr_i   (wr_clr),
        .iss_en_i   (iss_en),
        .iss_idx_i  (iss_idx),
        .busy_o     (busy),
        .busy_cnt_o (busy_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  ren;
        logic [1:0]  we;
        logic [4:0]  wi0;
        logic [63:0] wd0;
        logic [4:0]  wi1;
        logic [63:0] wd1;
        logic [1:0]  wc;
        logic        ie;
        logic [4:0]  ii;
        logic [4:0]  ri0;
        logic [4:0]  ri1;
        logic [63:0] ed0;
        logic [63:0] ed1;
        logic [1:0]  eb;
        logic [31:0] ebv;
        logic [5:0]  ecnt;
    } vec_t;

    vec_t tbl [16];

    logic [63:0] mreg  [32];
    logic        mbusy [32];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rd_en = 2'b00; rd_idx = '0; wr_en = 2'b00; wr_idx = '0;
        wr_data = '0; wr_clr = 2'b00; iss_en = 1'b0; iss_idx = '0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    function automatic int model_cnt();
        int c = 0;
        for (int r = 0; r < 32; r++) c += int'(mbusy[r]);
        return c;
    endfunction

    initial begin
        // ren we wi0 wd0 wi1 wd1 wc ie ii ri0 ri1 ed0 ed1 eb ebv ecnt
        tbl[0]  = '{2'b11, 2'b00, 5'd0, 64'h0,    5'd0, 64'h0,  2'b00, 1'b0, 5'd0, 5'd5, 5'd0, 64'h0,    64'h0,    2'b00, 32'h0,     6'd0};
        tbl[1]  = '{2'b11, 2'b01, 5'd3, 64'hDEAD, 5'd0, 64'h0,  2'b00, 1'b0, 5'd0, 5'd3, 5'd0, 64'hDEAD, 64'h0,    2'b00, 32'h0,     6'd0};
        tbl[2]  = '{2'b11, 2'b00, 5'd0, 64'h0,    5'd0, 64'h0,  2'b00, 1'b0, 5'd0, 5'd3, 5'd3, 64'hDEAD, 64'hDEAD, 2'b00, 32'h0,     6'd0};
        tbl[3]  = '{2'b11, 2'b11, 5'd7, 64'h11,   5'd7, 64'h22, 2'b00, 1'b0, 5'd0, 5'd7, 5'd3, 64'h22,   64'hDEAD, 2'b00, 32'h0,     6'd0};
        tbl[4]  = '{2'b11, 2'b01, 5'd0, 64'hFF,   5'd0, 64'h0,  2'b00, 1'b0, 5'd0, 5'd7, 5'd0, 64'h22,   64'h0,    2'b00, 32'h0,     6'd0};
        tbl[5]  = '{2'b11, 2'b00, 5'd0, 64'h0,    5'd0, 64'h0,  2'b00, 1'b1, 5'd9, 5'd9, 5'd0, 64'h0,    64'h0,    2'b00, 32'h0,     6'd0};
        tbl[6]  = '{2'b11, 2'b00, 5'd0, 64'h0,    5'd0, 64'h0,  2'b00, 1'b0, 5'd0, 5'd9, 5'd7, 64'h0,    64'h22,   2'b01, 32'h200,   6'd1};
        tbl[7]  = '{2'b11, 2'b01, 5'd9, 64'h5,    5'd0, 64'h0,  2'b01, 1'b0, 5'd0, 5'd9, 5'd9, 64'h5,    64'h5,    2'b00, 32'h200,   6'd1};
        tbl[8]  = '{2'b11, 2'b00, 5'd0, 64'h0,    5'd0, 64'h0,  2'b00, 1'b0, 5'd0, 5'd9, 5'd0, 64'h5,    64'h0,    2'b00, 32'h0,     6'd0};
        tbl[9]  = '{2'b11, 2'b00, 5'd0, 64'h0,    5'd0, 64'h0,  2'b00, 1'b1, 5'd4, 5'd4, 5'd9, 64'h0,    64'h5,    2'b00, 32'h0,     6'd0};
        tbl[10] = '{2'b11, 2'b01, 5'd4, 64'h44,   5'd0, 64'h0,  2'b01, 1'b1, 5'd4, 5'd4, 5'd0, 64'h44,   64'h0,    2'b00, 32'h10,    6'd1};
        tbl[11] = '{2'b11, 2'b00, 5'd0, 64'h0,    5'd0, 64'h0,  2'b00, 1'b1, 5'd0, 5'd4, 5'd0, 64'h44,   64'h0,    2'b01, 32'h10,    6'd1};
        tbl[12] = '{2'b11, 2'b00, 5'd0, 64'h0,    5'd0, 64'h0,  2'b00, 1'b0, 5'd0, 5'd0, 5'd4, 64'h0,    64'h44,   2'b10, 32'h10,    6'd1};
        tbl[13] = '{2'b00, 2'b00, 5'd0, 64'h0,    5'd0, 64'h0,  2'b00, 1'b0, 5'd0, 5'd4, 5'd7, 64'h0,    64'h0,    2'b00, 32'h10,    6'd1};
        tbl[14] = '{2'b11, 2'b11, 5'd4, 64'h1,    5'd4, 64'h2,  2'b01, 1'b0, 5'd0, 5'd4, 5'd7, 64'h2,    64'h22,   2'b00, 32'h10,    6'd1};
        tbl[15] = '{2'b11, 2'b00, 5'd0, 64'h0,    5'd0, 64'h0,  2'b00, 1'b0, 5'd0, 5'd4, 5'd0, 64'h2,    64'h0,    2'b00, 32'h0,     6'd0};

        rst = 1'b0;
        idle();
        do_reset();

        for (int i = 0; i < 16; i++) begin
            rd_en   = tbl[i].ren;
            rd_idx  = {tbl[i].ri1, tbl[i].ri0};
            wr_en   = tbl[i].we;
            wr_idx  = {tbl[i].wi1, tbl[i].wi0};
            wr_data = {tbl[i].wd1, tbl[i].wd0};
            wr_clr  = tbl[i].wc;
            iss_en  = tbl[i].ie;
            iss_idx = tbl[i].ii;
            #1;
            chk($sformatf("vec%0d rd_data0", i), rd_data[63:0], tbl[i].ed0);
            chk($sformatf("vec%0d rd_data1", i), rd_data[127:64], tbl[i].ed1);
            chk($sformatf("vec%0d rd_busy", i), 64'(rd_busy), 64'(tbl[i].eb));
            chk($sformatf("vec%0d busy_o", i), 64'(busy), 64'(tbl[i].ebv));
            chk($sformatf("vec%0d busy_cnt", i), 64'(busy_cnt), 64'(tbl[i].ecnt));
            step();
        end

        // Fill the scoreboard, then reset mid-operation with traffic present.
        idle();
        wr_en = 2'b01; wr_idx = {5'd0, 5'd5}; wr_data = {64'h0, 64'hCAFE};
        step();
        idle();
        for (int r = 1; r < 32; r++) begin
            iss_en = 1'b1; iss_idx = 5'(r);
            step();
        end
        idle();
        #1;
        chk("fill busy_cnt", 64'(busy_cnt), 64'd31);
        chk("fill busy_o", 64'(busy), 64'hFFFF_FFFE);
        rd_en = 2'b11; rd_idx = {5'd0, 5'd5};
        #1;
        chk("pre_rst x5", rd_data[63:0], 64'hCAFE);
        wr_en = 2'b11; wr_idx = {5'd6, 5'd5}; wr_data = {64'h66, 64'h55};
        iss_en = 1'b1; iss_idx = 5'd12;
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle();
        #1;
        chk("rst busy_o", 64'(busy), 64'h0);
        chk("rst busy_cnt", 64'(busy_cnt), 64'h0);
        for (int r = 0; r < 32; r += 2) begin
            rd_en = 2'b11; rd_idx = {5'(r + 1), 5'(r)};
            #1;
            chk($sformatf("rst x%0d", r), rd_data[63:0], 64'h0);
            chk($sformatf("rst x%0d", r + 1), rd_data[127:64], 64'h0);
        end

        // Randomised run against a plain array model.
        idle();
        do_reset();
        for (int r = 0; r < 32; r++) begin
            mreg[r] = '0;
            mbusy[r] = 1'b0;
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            logic [4:0]  ri [2];
            logic [4:0]  wi [2];
            logic [63:0] wd [2];
            rd_en  = 2'($urandom);
            wr_en  = 2'($urandom);
            wr_clr = 2'($urandom);
            iss_en = 1'($urandom);
            iss_idx = 5'($urandom_range(0, 7));
            for (int p = 0; p < 2; p++) begin
                ri[p] = 5'($urandom_range(0, 7));
                wi[p] = 5'($urandom_range(0, 7));
                wd[p] = {32'($urandom), 32'($urandom)};
            end
            rd_idx  = {ri[1], ri[0]};
            wr_idx  = {wi[1], wi[0]};
            wr_data = {wd[1], wd[0]};
            rst = ($urandom_range(0, 39) == 0);
            #1;
            for (int p = 0; p < 2; p++) begin
                logic [63:0] ed;
                logic        eb;
                logic        cleared;
                ed = 64'h0;
                eb = 1'b0;
                if (rd_en[p] && ri[p] != 0) begin
                    ed = mreg[ri[p]];
                    cleared = 1'b0;
                    for (int w = 0; w < 2; w++) begin
                        if (wr_en[w] && wi[w] == ri[p]) begin
                            ed = wd[w];
                            if (wr_clr[w]) cleared = 1'b1;
                        end
                    end
                    eb = mbusy[ri[p]] && !cleared;
                end
                chk($sformatf("rnd%0d rd_data%0d", cyc, p), rd_data[p*64 +: 64], ed);
                chk($sformatf("rnd%0d rd_busy%0d", cyc, p), 64'(rd_busy[p]), 64'(eb));
            end
            begin
                logic [31:0] ebv;
                for (int r = 0; r < 32; r++) ebv[r] = mbusy[r];
                chk($sformatf("rnd%0d busy_o", cyc), 64'(busy), 64'(ebv));
                chk($sformatf("rnd%0d busy_cnt", cyc), 64'(busy_cnt), 64'(model_cnt()));
            end
            if (rst) begin
                for (int r = 0; r < 32; r++) begin
                    mreg[r] = '0;
                    mbusy[r] = 1'b0;
                end
            end else begin
                for (int w = 0; w < 2; w++) begin
                    if (wr_en[w] && wi[w] != 0) mreg[wi[w]] = wd[w];
                    if (wr_en[w] && wr_clr[w]) mbusy[wi[w]] = 1'b0;
                end
                if (iss_en && iss_idx != 0) mbusy[iss_idx] = 1'b1;
            end
            step();
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
